mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory byte address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory word width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, maximum consecutive cycles the DMA may wait before it takes priority (range 1..15).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port cpu_rd, input, 1, MEM-stage MemRead.
REQ-007 SHALL have port cpu_wr, input, 1, MEM-stage MemWrite.
REQ-008 SHALL have port cpu_addr, input, ADDR_W, MEM-stage address (ALU result).
REQ-009 SHALL have port cpu_wdata, input, DATA_W, MEM-stage store data.
REQ-010 SHALL have port cpu_stall, output, 1, hold the pipeline (PC, IF/ID, ID/EX, EX/MEM) this cycle.
REQ-011 SHALL have port cpu_rvalid, output, 1, cpu_rdata valid this cycle.
REQ-012 SHALL have port cpu_rdata, output, DATA_W, load data to MEM/WB.
REQ-013 SHALL have port dma_req, input, 1, loader DMA access request, held until granted.
REQ-014 SHALL have port dma_we, input, 1, DMA access is a write.
REQ-015 SHALL have port dma_addr, input, ADDR_W, DMA address.
REQ-016 SHALL have port dma_wdata, input, DATA_W, DMA write data.
REQ-017 SHALL have port dma_gnt, output, 1, one-cycle pulse: DMA access issued this cycle.
REQ-018 SHALL have port dma_rvalid, output, 1, dma_rdata valid this cycle.
REQ-019 SHALL have port dma_rdata, output, DATA_W, DMA read data.
REQ-020 SHALL have ports mem_en, mem_we (output, 1), mem_addr (output, ADDR_W), mem_wdata (output, DATA_W), mem_rdata (input, DATA_W): single-port synchronous RAM, read data returned the cycle after issue.

Function
REQ-021 SHALL issue at most one memory access per cycle; mem_en high exactly in issue cycles, mem_addr/mem_we/mem_wdata from the granted requester, mem_we=0 on read issues.
REQ-022 SHALL treat cpu_rd and cpu_wr both high as a write; neither high means no CPU request.
REQ-023 SHALL grant CPU when it requests and starve_cnt < STARVE_MAX; otherwise grant DMA if dma_req.
REQ-024 SHALL keep starve_cnt (4 bits, saturating at STARVE_MAX): increment when dma_req high and not granted, clear on dma_gnt or when dma_req low.
REQ-025 SHALL, when starve_cnt == STARVE_MAX and dma_req high, grant DMA even if CPU requests, and assert cpu_stall that cycle.
REQ-026 SHALL, for a CPU read, use state machine IDLE -> CPU_RD (issue cycle, cpu_stall=1) -> CPU_DATA (cpu_rvalid=1, cpu_rdata=mem_rdata, cpu_stall=0) -> IDLE; one-cycle read stall per load.
REQ-027 SHALL complete a granted CPU write in its issue cycle with cpu_stall=0.
REQ-028 SHALL, for a DMA read issued in cycle N, assert dma_rvalid with dma_rdata=mem_rdata in cycle N+1; tracked by a 1-bit pending flag and owner, independent of CPU stall.
REQ-029 SHALL allow a new access to issue in the same cycle a previous read's data returns (back-to-back), except a CPU in CPU_DATA is not re-granted that cycle (its request is the completed one).
REQ-030 SHALL assert cpu_stall whenever the CPU requests and is not granted, and never when the CPU does not request.
REQ-031 SHALL pulse dma_gnt for exactly one cycle per DMA access; dma_req sampled low in the cycle after gnt means no further access.
REQ-032 SHALL drive cpu_rdata/dma_rdata to zero when their rvalid is low.

Reset
REQ-033 SHALL, while reset is high, force state IDLE, starve_cnt=0, read-pending=0, and drive cpu_stall=0, cpu_rvalid=0, dma_gnt=0, dma_rvalid=0, mem_en=0, mem_we=0, data outputs 0.
REQ-034 SHALL discard any outstanding read when reset asserts mid-operation; no rvalid appears after reset deasserts.

Verification
REQ-035 SHALL verify CPU load: cpu_rd=1, addr 0x10, RAM[0x10]=0xDEADBEEF -> cycle 0 mem_en=1, cpu_stall=1; cycle 1 cpu_rvalid=1, cpu_rdata=0xDEADBEEF, cpu_stall=0.
REQ-036 SHALL verify CPU store 0x12345678 to 0x20 -> single mem_en/mem_we cycle, cpu_stall=0, later read returns 0x12345678.
REQ-037 SHALL verify starvation: cpu_wr high continuously, dma_req high, STARVE_MAX=4 -> dma_gnt on 5th cycle, cpu_stall=1 only that cycle, starve_cnt back to 0.
REQ-038 SHALL verify DMA read back-to-back with CPU write: DMA read issued cycle N, CPU write issued N+1 -> dma_rvalid=1 at N+1 with correct data, both accesses on mem port.
REQ-039 SHALL verify reset mid-read: reset high in CPU_RD cycle -> next cycle all outputs 0, no cpu_rvalid after release.
REQ-040 SHALL verify idle: no requests for 10 cycles -> mem_en=0, cpu_stall=0, dma_gnt=0 throughout.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port RAM between the CPU MEM stage and a loader DMA.
// The CPU wins by default; a DMA that has waited STARVE_MAX cycles takes the port once.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, CPU_RD, CPU_DATA} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state_p1;
  state_t     phase;
  logic [3:0] starveCnt_p1;
  logic       rdPend_p1;
  logic       rdOwnerDma_p1;

  logic cpuWants;
  logic starved;
  logic cpuGnt;
  logic dmaGnt;
  logic cpuRdGnt;
  logic issueWe;

  // In CPU_DATA the CPU's held request is the load being completed, not a new one.
  assign cpuWants = (cpu_rd | cpu_wr) && (state_p1 != CPU_DATA);
  assign starved  = (starveCnt_p1 >= STARVE_LIM) && dma_req;
  assign cpuGnt   = !reset && cpuWants && !starved;
  assign dmaGnt   = !reset && dma_req && !cpuGnt;
  assign cpuRdGnt = cpuGnt && !cpu_wr;
  assign issueWe  = cpuGnt ? cpu_wr : (dmaGnt ? dma_we : 1'b0);

  always_comb begin
    phase = IDLE;
    if (state_p1 == CPU_DATA) phase = CPU_DATA;
    else if (cpuRdGnt)        phase = CPU_RD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1      <= IDLE;
      starveCnt_p1  <= '0;
      rdPend_p1     <= 1'b0;
      rdOwnerDma_p1 <= 1'b0;
    end else begin
      state_p1      <= cpuRdGnt ? CPU_DATA : IDLE;
      rdPend_p1     <= (cpuGnt || dmaGnt) && !issueWe;
      rdOwnerDma_p1 <= dmaGnt;
      if (dmaGnt || !dma_req)         starveCnt_p1 <= '0;
      else if (starveCnt_p1 < STARVE_LIM) starveCnt_p1 <= starveCnt_p1 + 4'd1;
    end
  end

  // Issue stage: the granted requester drives the RAM port this cycle.
  always_comb begin
    mem_en    = cpuGnt || dmaGnt;
    mem_we    = issueWe;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpuGnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dmaGnt) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  assign dma_gnt   = dmaGnt;
  assign cpu_stall = !reset && ((cpuWants && !cpuGnt) || (phase == CPU_RD));

  // Return stage: read data arrives one cycle after issue.
  assign cpu_rvalid = !reset && (phase == CPU_DATA);
  assign dma_rvalid = !reset && rdPend_p1 && rdOwnerDma_p1;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural sync RAM, shadow memory for expected data,
// and per-requester read-data queues popped when rvalid appears.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] ram    [256];
  logic [31:0] shadow [256];
  logic [31:0] cpuQ [$];
  logic [31:0] dmaQ [$];
  logic [31:0] expData;
  int nCmp = 0;
  int nErr = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[9:2]];
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
  endtask

  task automatic test_reset();
    reset = 1; cpu_rd = 1; cpu_addr = 32'h10; dma_req = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      nCmp++; if (mem_en !== 1'b0) begin nErr++; $display("FAIL reset_mem_en got=%0b exp=0", mem_en); end
      nCmp++; if (mem_we !== 1'b0) begin nErr++; $display("FAIL reset_mem_we got=%0b exp=0", mem_we); end
      nCmp++; if (cpu_stall !== 1'b0) begin nErr++; $display("FAIL reset_cpu_stall got=%0b exp=0", cpu_stall); end
      nCmp++; if (dma_gnt !== 1'b0) begin nErr++; $display("FAIL reset_dma_gnt got=%0b exp=0", dma_gnt); end
      nCmp++; if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin nErr++; $display("FAIL reset_rvalid got=%0b%0b exp=00", cpu_rvalid, dma_rvalid); end
      nCmp++; if (mem_addr !== 32'h0) begin nErr++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
      nextCycle();
    end
    clearInputs();
    reset = 0;
    nextCycle();
  endtask

  task automatic test_cpu_load();
    cpu_rd = 1; cpu_addr = 32'h10;
    @(negedge clk);
    nCmp++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin nErr++; $display("FAIL load_issue got en=%0b we=%0b exp en=1 we=0", mem_en, mem_we); end
    nCmp++; if (cpu_stall !== 1'b1) begin nErr++; $display("FAIL load_issue_stall got=%0b exp=1", cpu_stall); end
    nCmp++; if (mem_addr !== 32'h10) begin nErr++; $display("FAIL load_addr got=%h exp=00000010", mem_addr); end
    cpuQ.push_back(shadow[8'h04]);
    nextCycle();
    @(negedge clk);
    nCmp++; if (cpu_rvalid !== 1'b1 || cpu_stall !== 1'b0) begin nErr++; $display("FAIL load_data_ctl got rvalid=%0b stall=%0b exp rvalid=1 stall=0", cpu_rvalid, cpu_stall); end
    nCmp++; if (mem_en !== 1'b0) begin nErr++; $display("FAIL load_no_regrant got=%0b exp=0", mem_en); end
    expData = (cpuQ.size() > 0) ? cpuQ.pop_front() : 32'hxxxxxxxx;
    nCmp++; if (cpu_rdata !== expData) begin nErr++; $display("FAIL load_rdata got=%h exp=%h", cpu_rdata, expData); end
    nextCycle();
    clearInputs();
    @(negedge clk);
    nCmp++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin nErr++; $display("FAIL load_after got rvalid=%0b rdata=%h exp 0", cpu_rvalid, cpu_rdata); end
    nextCycle();
  endtask

  task automatic test_cpu_store();
    cpu_wr = 1; cpu_addr = 32'h20; cpu_wdata = 32'h12345678;
    @(negedge clk);
    nCmp++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin nErr++; $display("FAIL store_issue got en=%0b we=%0b exp 11", mem_en, mem_we); end
    nCmp++; if (cpu_stall !== 1'b0) begin nErr++; $display("FAIL store_stall got=%0b exp=0", cpu_stall); end
    nCmp++; if (mem_wdata !== 32'h12345678 || mem_addr !== 32'h20) begin nErr++; $display("FAIL store_bus got addr=%h data=%h exp 00000020/12345678", mem_addr, mem_wdata); end
    shadow[8'h08] = 32'h12345678;
    nextCycle();
    clearInputs();
    @(negedge clk);
    nCmp++; if (mem_en !== 1'b0) begin nErr++; $display("FAIL store_single got=%0b exp=0", mem_en); end
    nextCycle();
    cpu_rd = 1; cpu_addr = 32'h20;
    cpuQ.push_back(shadow[8'h08]);
    nextCycle();
    @(negedge clk);
    expData = (cpuQ.size() > 0) ? cpuQ.pop_front() : 32'hxxxxxxxx;
    nCmp++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== expData) begin nErr++; $display("FAIL store_readback got v=%0b d=%h exp v=1 d=%h", cpu_rvalid, cpu_rdata, expData); end
    nextCycle();
    clearInputs();
    nextCycle();
  endtask

  task automatic test_starvation();
    logic expGnt;
    for (int i = 1; i <= 11; i++) begin
      cpu_wr = 1; cpu_addr = 32'h40; cpu_wdata = i;
      dma_req = (i != 6); dma_we = 0; dma_addr = 32'h10;
      expGnt = (i == 5) || (i == 11);
      @(negedge clk);
      nCmp++; if (dma_gnt !== expGnt) begin nErr++; $display("FAIL starve_gnt_c%0d got=%0b exp=%0b", i, dma_gnt, expGnt); end
      nCmp++; if (cpu_stall !== expGnt) begin nErr++; $display("FAIL starve_stall_c%0d got=%0b exp=%0b", i, cpu_stall, expGnt); end
      nCmp++; if (mem_en !== 1'b1 || mem_we !== !expGnt) begin nErr++; $display("FAIL starve_port_c%0d got en=%0b we=%0b exp en=1 we=%0b", i, mem_en, mem_we, !expGnt); end
      if (i == 6) begin
        expData = (dmaQ.size() > 0) ? dmaQ.pop_front() : 32'hxxxxxxxx;
        nCmp++; if (dma_rvalid !== 1'b1 || dma_rdata !== expData) begin nErr++; $display("FAIL starve_dma_rd got v=%0b d=%h exp v=1 d=%h", dma_rvalid, dma_rdata, expData); end
      end
      if (expGnt) dmaQ.push_back(shadow[8'h04]);
      else        shadow[8'h10] = i;
      nextCycle();
    end
    clearInputs();
    @(negedge clk);
    expData = (dmaQ.size() > 0) ? dmaQ.pop_front() : 32'hxxxxxxxx;
    nCmp++; if (dma_rvalid !== 1'b1 || dma_rdata !== expData) begin nErr++; $display("FAIL starve_dma_rd2 got v=%0b d=%h exp v=1 d=%h", dma_rvalid, dma_rdata, expData); end
    nextCycle();
  endtask

  task automatic test_back_to_back();
    dma_req = 1; dma_we = 0; dma_addr = 32'h20;
    @(negedge clk);
    nCmp++; if (dma_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0) begin nErr++; $display("FAIL b2b_dma_issue got gnt=%0b en=%0b we=%0b exp 1/1/0", dma_gnt, mem_en, mem_we); end
    dmaQ.push_back(shadow[8'h08]);
    nextCycle();
    dma_req = 0; cpu_wr = 1; cpu_addr = 32'h24; cpu_wdata = 32'hCAFEF00D;
    @(negedge clk);
    expData = (dmaQ.size() > 0) ? dmaQ.pop_front() : 32'hxxxxxxxx;
    nCmp++; if (dma_rvalid !== 1'b1 || dma_rdata !== expData) begin nErr++; $display("FAIL b2b_dma_rd got v=%0b d=%h exp v=1 d=%h", dma_rvalid, dma_rdata, expData); end
    nCmp++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h24) begin nErr++; $display("FAIL b2b_cpu_wr got en=%0b we=%0b addr=%h exp 1/1/00000024", mem_en, mem_we, mem_addr); end
    nCmp++; if (cpu_stall !== 1'b0 || dma_gnt !== 1'b0) begin nErr++; $display("FAIL b2b_ctl got stall=%0b gnt=%0b exp 0/0", cpu_stall, dma_gnt); end
    shadow[8'h09] = 32'hCAFEF00D;
    nextCycle();
    cpu_wr = 0; cpu_rd = 1; cpu_addr = 32'h24;
    cpuQ.push_back(shadow[8'h09]);
    nextCycle();
    @(negedge clk);
    expData = (cpuQ.size() > 0) ? cpuQ.pop_front() : 32'hxxxxxxxx;
    nCmp++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== expData) begin nErr++; $display("FAIL b2b_readback got v=%0b d=%h exp v=1 d=%h", cpu_rvalid, cpu_rdata, expData); end
    nextCycle();
    clearInputs();
    nextCycle();
  endtask

  task automatic test_dma_in_cpu_data();
    cpu_rd = 1; cpu_addr = 32'h10;
    dma_req = 1; dma_we = 1; dma_addr = 32'h30; dma_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    nCmp++; if (dma_gnt !== 1'b0 || cpu_stall !== 1'b1 || mem_addr !== 32'h10) begin nErr++; $display("FAIL cd_issue got gnt=%0b stall=%0b addr=%h exp 0/1/00000010", dma_gnt, cpu_stall, mem_addr); end
    cpuQ.push_back(shadow[8'h04]);
    nextCycle();
    @(negedge clk);
    expData = (cpuQ.size() > 0) ? cpuQ.pop_front() : 32'hxxxxxxxx;
    nCmp++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== expData) begin nErr++; $display("FAIL cd_cpu_rd got v=%0b d=%h exp v=1 d=%h", cpu_rvalid, cpu_rdata, expData); end
    nCmp++; if (dma_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h30) begin nErr++; $display("FAIL cd_dma_wr got gnt=%0b we=%0b addr=%h exp 1/1/00000030", dma_gnt, mem_we, mem_addr); end
    nCmp++; if (cpu_stall !== 1'b0) begin nErr++; $display("FAIL cd_stall got=%0b exp=0", cpu_stall); end
    shadow[8'h0C] = 32'hA5A5A5A5;
    nextCycle();
    clearInputs();
    @(negedge clk);
    nCmp++; if (dma_rvalid !== 1'b0 || dma_gnt !== 1'b0) begin nErr++; $display("FAIL cd_no_dma_rd got v=%0b gnt=%0b exp 0/0", dma_rvalid, dma_gnt); end
    nextCycle();
    cpu_rd = 1; cpu_addr = 32'h30;
    cpuQ.push_back(shadow[8'h0C]);
    nextCycle();
    @(negedge clk);
    expData = (cpuQ.size() > 0) ? cpuQ.pop_front() : 32'hxxxxxxxx;
    nCmp++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== expData) begin nErr++; $display("FAIL cd_readback got v=%0b d=%h exp v=1 d=%h", cpu_rvalid, cpu_rdata, expData); end
    nextCycle();
    clearInputs();
    nextCycle();
  endtask

  task automatic test_reset_mid_read();
    cpu_rd = 1; cpu_addr = 32'h10;
    @(negedge clk);
    nCmp++; if (mem_en !== 1'b1 || cpu_stall !== 1'b1) begin nErr++; $display("FAIL rmr_issue got en=%0b stall=%0b exp 1/1", mem_en, cpu_stall); end
    #1 reset = 1;
    nextCycle();
    cpu_rd = 0;
    @(negedge clk);
    nCmp++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin nErr++; $display("FAIL rmr_rvalid got v=%0b d=%h exp 0/0", cpu_rvalid, cpu_rdata); end
    nCmp++; if (mem_en !== 1'b0 || cpu_stall !== 1'b0 || dma_gnt !== 1'b0) begin nErr++; $display("FAIL rmr_ctl got en=%0b stall=%0b gnt=%0b exp 0/0/0", mem_en, cpu_stall, dma_gnt); end
    nextCycle();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nCmp++; if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin nErr++; $display("FAIL rmr_after_c%0d got v=%0b%0b exp 00", i, cpu_rvalid, dma_rvalid); end
      nextCycle();
    end
  endtask

  task automatic test_idle();
    clearInputs();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      nCmp++; if (mem_en !== 1'b0) begin nErr++; $display("FAIL idle_mem_en_c%0d got=%0b exp=0", i, mem_en); end
      nCmp++; if (cpu_stall !== 1'b0) begin nErr++; $display("FAIL idle_stall_c%0d got=%0b exp=0", i, cpu_stall); end
      nCmp++; if (dma_gnt !== 1'b0) begin nErr++; $display("FAIL idle_gnt_c%0d got=%0b exp=0", i, dma_gnt); end
      nCmp++; if (cpu_rdata !== 32'h0 || dma_rdata !== 32'h0) begin nErr++; $display("FAIL idle_rdata_c%0d got=%h/%h exp 0", i, cpu_rdata, dma_rdata); end
      nextCycle();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 32'h1000_0000 + i;
      shadow[i] = 32'h1000_0000 + i;
    end
    ram[8'h04] = 32'hDEADBEEF;
    shadow[8'h04] = 32'hDEADBEEF;
    mem_rdata = 32'h0;
    reset = 1;
    clearInputs();
    nextCycle();
    test_reset();
    test_cpu_load();
    test_cpu_store();
    test_starvation();
    test_back_to_back();
    test_dma_in_cpu_data();
    test_reset_mid_read();
    test_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
